// File: rtl/piano_pkg.sv
// Shared types and constants for the voice scheduler slice.
// Envelope state encoding and voice-count limits.
package piano_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ATTACK,
    SUSTAIN,
    DECAY
  } env_state_t;

  localparam int NUM_VOICES = 3;
  localparam logic [7:0] GAIN_MAX = 8'd255;

endpackage

// File: rtl/voice_envelope.sv
// Per-slot attack/sustain/decay envelope.
// Events take priority over the tick in the same cycle.
module voice_envelope
  import piano_pkg::*;
#(
  parameter int ATTACK_STEP   = 8,
  parameter int SUSTAIN_TICKS = 100,
  parameter int DECAY_STEP    = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       start,
  input  logic       retrig,
  input  logic       rel,
  output env_state_t state,
  output logic [7:0] gain
);

  env_state_t  st_q, st_d;
  logic [7:0]  g_q, g_d;
  logic [15:0] h_q, h_d;
  logic [8:0]  up, dn;
  logic        live;

  assign up   = {1'b0, g_q} + 9'(ATTACK_STEP);
  assign dn   = {1'b0, g_q} - 9'(DECAY_STEP);
  assign live = (st_q == ATTACK) || (st_q == SUSTAIN);

  // State, gain and hold counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q <= IDLE;
      g_q  <= '0;
      h_q  <= '0;
    end else begin
      st_q <= st_d;
      g_q  <= g_d;
      h_q  <= h_d;
    end
  end

  // Next state: events first, otherwise advance on tick
  always_comb begin
    st_d = st_q;
    g_d  = g_q;
    h_d  = h_q;
    if (start) begin
      st_d = ATTACK;
      g_d  = '0;
    end else if (retrig) begin
      st_d = ATTACK;
    end else if (rel && live) begin
      st_d = DECAY;
    end else if (tick) begin
      case (st_q)
        ATTACK: begin
          if (up[8] || up[7:0] == GAIN_MAX) begin
            g_d  = GAIN_MAX;
            st_d = SUSTAIN;
            h_d  = '0;
          end else begin
            g_d = up[7:0];
          end
        end
        SUSTAIN: begin
          g_d = GAIN_MAX;
          h_d = h_q + 16'd1;
          if (h_d >= 16'(SUSTAIN_TICKS))
            st_d = DECAY;
        end
        DECAY: begin
          if (dn[8] || dn[7:0] == 8'd0) begin
            g_d  = '0;
            st_d = IDLE;
          end else begin
            g_d = dn[7:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs straight from the registers
  always_comb begin
    state = st_q;
    gain  = g_q;
  end

endmodule

// File: rtl/voice_scheduler.sv
// Three-voice key scheduler: handshake, allocation,
// age ranking and a shared envelope tick prescaler.
module voice_scheduler
  import piano_pkg::*;
#(
  parameter int TICK_DIV      = 20000,
  parameter int ATTACK_STEP   = 8,
  parameter int SUSTAIN_TICKS = 100,
  parameter int DECAY_STEP    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        evt_valid,
  output logic        evt_ready,
  input  logic        evt_press,
  input  logic [7:0]  evt_key,
  output logic [23:0] voice_note,
  output logic [23:0] voice_gain,
  output logic [2:0]  voice_active,
  output logic [1:0]  notescount
);

  localparam logic [23:0] TOP = 24'(TICK_DIV - 1);

  logic [23:0] cnt;
  logic        tick;
  logic        busy;
  logic        acc;
  logic        do_press;
  logic        do_rel;

  logic [7:0]  note [NUM_VOICES];
  logic [1:0]  rank [NUM_VOICES];
  env_state_t  st   [NUM_VOICES];
  logic [7:0]  gain [NUM_VOICES];

  logic [2:0]  act, hit;
  logic [2:0]  start, retrig, rel;
  logic [1:0]  sel, hit_sel, idle_sel, old_sel;
  logic        has_idle;

  assign tick      = (cnt == TOP);
  assign evt_ready = ~busy;
  assign acc       = evt_valid & ~busy;
  assign do_press  = acc & evt_press & (evt_key != 8'd0);
  assign do_rel    = acc & ~evt_press & (evt_key != 8'd0);

  // Free-running envelope prescaler
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt <= '0;
    else
      cnt <= tick ? '0 : cnt + 24'd1;
  end

  // Ready drops for one cycle after each accepted event
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      busy <= 1'b0;
    else
      busy <= acc;
  end

  // Slot occupancy and key match
  always_comb begin
    act = '0;
    hit = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      act[i] = (st[i] != IDLE);
      hit[i] = act[i] && (note[i] == evt_key);
    end
  end

  // Pick retrigger slot, else lowest idle, else oldest
  always_comb begin
    hit_sel  = '0;
    idle_sel = '0;
    old_sel  = '0;
    has_idle = 1'b0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (hit[i])
        hit_sel = 2'(i);
      if (!act[i]) begin
        idle_sel = 2'(i);
        has_idle = 1'b1;
      end
      if (rank[i] == 2'd2)
        old_sel = 2'(i);
    end
    sel = old_sel;
    if (|hit)
      sel = hit_sel;
    else if (has_idle)
      sel = idle_sel;
  end

  // One-hot envelope controls for this cycle
  always_comb begin
    start  = '0;
    retrig = '0;
    rel    = '0;
    if (do_press) begin
      if (|hit)
        retrig[sel] = 1'b1;
      else
        start[sel] = 1'b1;
    end
    if (do_rel) begin
      for (int i = 0; i < NUM_VOICES; i++)
        rel[i] = hit[i] &&
                 (st[i] == ATTACK || st[i] == SUSTAIN);
    end
  end

  // Note latch and age ranks on every press
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        note[i] <= '0;
        rank[i] <= 2'(i);
      end
    end else if (do_press) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (2'(i) == sel) begin
          rank[i] <= 2'd0;
          if (!(|hit))
            note[i] <= evt_key;
        end else if (rank[i] < rank[sel]) begin
          rank[i] <= rank[i] + 2'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_env
    voice_envelope #(
      .ATTACK_STEP   (ATTACK_STEP),
      .SUSTAIN_TICKS (SUSTAIN_TICKS),
      .DECAY_STEP    (DECAY_STEP)
    ) u_env (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick),
      .start   (start[g]),
      .retrig  (retrig[g]),
      .rel     (rel[g]),
      .state   (st[g]),
      .gain    (gain[g])
    );
  end

  // Idle slots report note 0 regardless of the stale latch
  always_comb begin
    voice_note = '0;
    voice_gain = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_note[8*i +: 8] = act[i] ? note[i] : 8'd0;
      voice_gain[8*i +: 8] = gain[i];
    end
    voice_active = act;
    notescount = 2'(act[0]) + 2'(act[1]) + 2'(act[2]);
  end

endmodule

// File: tb/tb_voice_scheduler.sv
// Bench for voice_scheduler: per-cycle vector tables
// fed through a scoreboard, plus async reset checks.
module tb_voice_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        evt_valid = 1'b0;
  logic        evt_press = 1'b0;
  logic [7:0]  evt_key = 8'd0;
  logic        evt_ready;
  logic [23:0] voice_note;
  logic [23:0] voice_gain;
  logic [2:0]  voice_active;
  logic [1:0]  notescount;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  voice_scheduler #(
    .TICK_DIV      (4),
    .ATTACK_STEP   (128),
    .SUSTAIN_TICKS (2),
    .DECAY_STEP    (128)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_press    (evt_press),
    .evt_key      (evt_key),
    .voice_note   (voice_note),
    .voice_gain   (voice_gain),
    .voice_active (voice_active),
    .notescount   (notescount)
  );

  typedef struct {
    logic        v;
    logic        p;
    logic [7:0]  k;
    logic [23:0] note;
    logic [23:0] gain;
    logic [2:0]  act;
    logic        rdy;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic logic [23:0] p3(
    input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    return {c, b, a};
  endfunction

  task automatic add(input logic v, input logic p,
                     input logic [7:0] k, input logic [23:0] n,
                     input logic [23:0] g, input logic [2:0] a,
                     input logic r);
    vec_t t;
    t.v = v; t.p = p; t.k = k;
    t.note = n; t.gain = g; t.act = a; t.rdy = r;
    tbl.push_back(t);
  endtask

  task automatic idle(input int n, input logic [23:0] nn,
                      input logic [23:0] gg, input logic [2:0] a);
    repeat (n) add(1'b0, 1'b0, 8'd0, nn, gg, a, 1'b1);
  endtask

  task automatic chk(input string nm, input logic [23:0] got,
                     input logic [23:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic run(input string ph);
    vec_t e;
    for (int i = 0; i < tbl.size(); i++) begin
      evt_valid = tbl[i].v;
      evt_press = tbl[i].p;
      evt_key   = tbl[i].k;
      sb.push_back(tbl[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("%s[%0d] note", ph, i), voice_note, e.note);
      chk($sformatf("%s[%0d] gain", ph, i), voice_gain, e.gain);
      chk($sformatf("%s[%0d] active", ph, i),
          {21'd0, voice_active}, {21'd0, e.act});
      chk($sformatf("%s[%0d] count", ph, i),
          {22'd0, notescount}, 24'($countones(e.act)));
      chk($sformatf("%s[%0d] ready", ph, i),
          {23'd0, evt_ready}, {23'd0, e.rdy});
    end
    tbl.delete();
    evt_valid = 1'b0;
    evt_press = 1'b0;
    evt_key   = 8'd0;
  endtask

  task automatic do_reset(input string ph);
    #2;
    reset_n   = 1'b0;
    evt_valid = 1'b0;
    evt_press = 1'b0;
    evt_key   = 8'd0;
    #1;
    chk({ph, " rst note"}, voice_note, 24'd0);
    chk({ph, " rst gain"}, voice_gain, 24'd0);
    chk({ph, " rst active"}, {21'd0, voice_active}, 24'd0);
    chk({ph, " rst count"}, {22'd0, notescount}, 24'd0);
    chk({ph, " rst ready"}, {23'd0, evt_ready}, 24'd1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  localparam logic [23:0] Z = 24'd0;

  initial begin
    logic [23:0] n;
    do_reset("init");

    // single key full envelope
    n = p3(8'h3C, 0, 0);
    add(1, 1, 8'h3C, n, Z, 3'b001, 0);
    idle(2, n, Z, 3'b001);
    idle(4, n, p3(128, 0, 0), 3'b001);
    idle(12, n, p3(255, 0, 0), 3'b001);
    idle(4, n, p3(127, 0, 0), 3'b001);
    idle(1, Z, Z, 3'b000);
    run("single");

    // fill three slots then steal the oldest
    add(1, 1, 8'h10, p3(8'h10, 0, 0), Z, 3'b001, 0);
    idle(1, p3(8'h10, 0, 0), Z, 3'b001);
    add(1, 1, 8'h20, p3(8'h10, 8'h20, 0), Z, 3'b011, 0);
    idle(1, p3(8'h10, 8'h20, 0), p3(128, 128, 0), 3'b011);
    add(1, 1, 8'h30, p3(8'h10, 8'h20, 8'h30),
        p3(128, 128, 0), 3'b111, 0);
    idle(1, p3(8'h10, 8'h20, 8'h30), p3(128, 128, 0), 3'b111);
    add(1, 1, 8'h40, p3(8'h40, 8'h20, 8'h30),
        p3(0, 128, 0), 3'b111, 0);
    idle(1, p3(8'h40, 8'h20, 8'h30), p3(128, 255, 128), 3'b111);
    run("steal");

    do_reset("sustain");

    // release from sustain, then retrigger in decay
    n = p3(8'h3C, 0, 0);
    add(1, 1, 8'h3C, n, Z, 3'b001, 0);
    idle(2, n, Z, 3'b001);
    idle(4, n, p3(128, 0, 0), 3'b001);
    idle(1, n, p3(255, 0, 0), 3'b001);
    add(1, 0, 8'h3C, n, p3(255, 0, 0), 3'b001, 0);
    idle(2, n, p3(255, 0, 0), 3'b001);
    idle(4, n, p3(127, 0, 0), 3'b001);
    idle(1, Z, Z, 3'b000);
    add(1, 1, 8'h3C, n, Z, 3'b001, 0);
    idle(2, n, Z, 3'b001);
    idle(4, n, p3(128, 0, 0), 3'b001);
    idle(12, n, p3(255, 0, 0), 3'b001);
    idle(1, n, p3(127, 0, 0), 3'b001);
    add(1, 1, 8'h3C, n, p3(127, 0, 0), 3'b001, 0);
    idle(2, n, p3(127, 0, 0), 3'b001);
    idle(12, n, p3(255, 0, 0), 3'b001);
    idle(4, n, p3(127, 0, 0), 3'b001);
    add(1, 1, 8'h77, p3(0, 8'h77, 0), Z, 3'b010, 0);
    idle(1, p3(0, 8'h77, 0), Z, 3'b010);
    run("relret");

    do_reset("attack");

    // held valid, ignored events, event on tick edge
    n = p3(8'h11, 8'h33, 0);
    idle(1, Z, Z, 3'b000);
    add(1, 1, 8'h11, p3(8'h11, 0, 0), Z, 3'b001, 0);
    add(1, 1, 8'h22, p3(8'h11, 0, 0), Z, 3'b001, 1);
    add(1, 1, 8'h33, n, p3(128, 0, 0), 3'b011, 0);
    add(1, 1, 8'h44, n, p3(128, 0, 0), 3'b011, 1);
    add(1, 0, 8'h55, n, p3(128, 0, 0), 3'b011, 0);
    idle(1, n, p3(128, 0, 0), 3'b011);
    add(1, 1, 8'h11, n, p3(128, 128, 0), 3'b011, 0);
    idle(1, n, p3(128, 128, 0), 3'b011);
    add(1, 1, 8'h00, n, p3(128, 128, 0), 3'b011, 0);
    idle(1, n, p3(128, 128, 0), 3'b011);
    idle(1, n, p3(255, 255, 0), 3'b011);
    run("hs");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/voice_scheduler.md
# voice_scheduler

Three-voice scheduler between key-event decoding and the per-voice attenuation/mixing datapath. Accepts key press/release events over a valid/ready handshake, assigns each pressed key to one of three voice slots, and runs one attack/sustain/decay envelope per slot from a shared tick prescaler. Drives each slot's note code and 8-bit gain, plus the active-voice count the mixer uses to normalise amplitude.

## Interface
Parameters:
- TICK_DIV, 20000: clk cycles per envelope tick; legal range 2..2^24.
- ATTACK_STEP, 8: gain increment per tick in ATTACK.
- SUSTAIN_TICKS, 100: ticks held at full gain before automatic decay.
- DECAY_STEP, 2: gain decrement per tick in DECAY.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- evt_valid  in  1  key event present.
- evt_ready  out  1  scheduler can accept an event.
- evt_press  in  1  1 = press, 0 = release.
- evt_key  in  8  key code; 0 is reserved and ignored.
- voice_note  out  3x8  note code per slot; 0 when the slot is idle.
- voice_gain  out  3x8  envelope gain per slot, 0..255 (255 = unity).
- voice_active  out  3  slot is not IDLE.
- notescount  out  2  popcount of voice_active.

## Operation
- Reset (asynchronous): all slots IDLE with note 0 and gain 0; ranks = slot index; prescaler 0. evt_ready = 1 and every other output is 0.
- Handshake: an event is accepted on a rising clk edge with evt_valid & evt_ready. evt_ready is 0 for exactly the one cycle after an acceptance, then returns to 1. Events with evt_key = 0 are accepted and dropped.
- Press allocation, in priority order:
  1. A slot already holds evt_key and is not IDLE: retrigger it. State goes to ATTACK and gain is kept.
  2. Otherwise, use the lowest-index IDLE slot. It loads the key with gain 0 and state ATTACK.
  3. Otherwise, steal the slot with rank 2 (oldest). It loads the key with gain 0 and state ATTACK.
- Rank: a 2-bit age per slot, always a permutation of 0..2. Slots are ranked 0 (newest) to 2 (oldest).
  - The allocated or retriggered slot gets rank 0.
  - Every slot whose old rank was below that slot's old rank increments by 1.
- Release: the matching non-IDLE slot in ATTACK or SUSTAIN goes to DECAY. A release for a slot already in DECAY, or for a key with no matching slot, is ignored.
- Envelope states, per slot, advanced only on tick:
  - IDLE: no change.
  - ATTACK: gain = min(gain + ATTACK_STEP, 255). On reaching 255, go to SUSTAIN and clear the hold counter.
  - SUSTAIN: gain holds at 255. The hold counter increments; at SUSTAIN_TICKS, go to DECAY.
  - DECAY: gain = max(gain - DECAY_STEP, 0). On reaching 0, go to IDLE and set the note to 0.
- Arithmetic: compute add/subtract at 9 bits, then saturate to 8 bits. No wrap-around is permitted.
- Prescaler: counts 0..TICK_DIV-1. tick is asserted for one cycle when the count equals TICK_DIV-1, and the counter wraps to 0 on that cycle.

## Timing
- Outputs are registered. An event accepted at edge N is visible on voice_note, voice_gain, voice_active and notescount after edge N.
- Tick effects are visible after the tick edge.
- Event and tick in the same cycle on the same slot: the event's transition applies and the tick is skipped for that slot only. Other slots still tick.
- DECAY reaching 0 in the same cycle as a press that would choose the lowest-index IDLE slot: that slot is not yet IDLE, so allocation uses the pre-edge states.
- notescount always equals popcount(voice_active) on the same cycle; no extra latency.
- reset_n assertion mid-envelope or mid-handshake clears everything immediately. The first event can be accepted at the first clk edge after deassertion.

## Structure
- piano_pkg holds:
  - typedef env_state_t {IDLE, ATTACK, SUSTAIN, DECAY};
  - NUM_VOICES = 3;
  - GAIN_MAX = 8'd255.
- Sub-module voice_envelope: one instance per slot. It contains the state, gain and hold counter, and takes tick, start (load gain 0), retrigger (keep gain) and release inputs.
- The top level holds the prescaler, rank logic, key match/allocation and the handshake.

## Test plan
Run all scenarios with TICK_DIV=4, ATTACK_STEP=128, SUSTAIN_TICKS=2, DECAY_STEP=128.
- Single key: press 0x3C. The next cycle shows slot0 note 0x3C, active 3'b001, notescount 1.
  - Gain then goes 128, 255 on successive ticks, holds 255 for 2 ticks, then 127, 0.
  - After gain reaches 0: slot0 IDLE, note 0, notescount 0.
- Fill and steal: press 0x10, 0x20, 0x30, then 0x40 → 0x40 lands in slot0 (oldest) with gain 0, and notescount stays 3.
- Release: press 0x3C, wait for gain 255, release 0x3C → DECAY begins at once; the next tick gives gain 127.
- Retrigger: press 0x3C, let it enter DECAY at gain 127, press 0x3C again → same slot, ATTACK, and the next tick gives gain 255.
- Handshake and ignore cases: hold evt_valid high for 4 cycles → exactly 2 acceptances, with evt_ready pattern 1,0,1,0.
  - Releasing key 0x55 that was never pressed produces no output change.
  - evt_key 0 produces no output change.
- Reset mid-operation: pull reset_n low while slots are in SUSTAIN → all outputs are 0 immediately and evt_ready is 1. A press after release of reset lands in slot0.
